// File: rtl/wbm_cmd_master.sv
// -----------------------------------------------------------------------------
// wbm_cmd_master
//
// Wishbone classic initiator for the command/management path. Each accepted
// single-word command becomes one Wishbone read or write cycle towards the
// slave-side arbiter. An err from the arbiter (its own window timeout) makes
// the block retry the cycle up to RETRIES more times, with one idle gap
// cycle between attempts. A local watchdog aborts the cycle if neither ack
// nor err arrives within TIMEOUT bus cycles. Every command ends in a single
// rsp_valid pulse that carries data and status.
//
// Parameters:
//   TIMEOUT  bus cycles per attempt before a local abort (must be > 0)
//   RETRIES  extra attempts after an err response (0..7)
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   cmd_valid/cmd_ready command handshake; a command is taken on a clk edge
//                       where both are high
//   cmd_we/adr/dat      command fields, captured at acceptance
//   rsp_valid           one-cycle response strobe (no backpressure)
//   rsp_dat/rsp_status  read data (0 for writes and failures);
//                       status 00 ok, 01 bus error, 10 local timeout
//   wb_*                Wishbone classic initiator signals
//
// Handshake: cmd_valid/cmd_ready transfer a command on any clk edge where
// both are high; cmd_valid may be held without cmd_ready and the command is
// taken later. rsp_valid is a pure strobe and is never stalled.
// -----------------------------------------------------------------------------
module wbm_cmd_master #(
    parameter logic [19:0] TIMEOUT = 20'd1024,
    parameter int unsigned RETRIES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [15:0] cmd_adr,
    input  logic [15:0] cmd_dat,
    output logic        rsp_valid,
    output logic [15:0] rsp_dat,
    output logic [1:0]  rsp_status,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0]  RETRY_MAX = 3'(RETRIES);
    localparam logic [19:0] WDOG_LAST = TIMEOUT - 20'd1;
    localparam logic [19:0] WDOG_SAT  = 20'hFFFFF;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_BERR = 2'b01;
    localparam logic [1:0] ST_TOUT = 2'b10;

    state_t      state_q,      state_d;
    logic        we_q,         we_d;
    logic [15:0] adr_q,        adr_d;
    logic [15:0] dat_q,        dat_d;
    logic [19:0] wdog_q,       wdog_d;
    logic [2:0]  retry_q,      retry_d;
    logic [15:0] rsp_dat_q,    rsp_dat_d;
    logic [1:0]  rsp_status_q, rsp_status_d;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        wdog_d       = wdog_q;
        retry_d      = retry_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    retry_d = 3'd0;
                    wdog_d  = 20'd0;
                    state_d = BUS;
                end
            end

            BUS: begin
                // Saturating count of cycles spent in this attempt.
                if (wdog_q != WDOG_SAT) begin
                    wdog_d = wdog_q + 20'd1;
                end
                // The watchdog test uses the pre-increment value, so the
                // attempt lasts exactly TIMEOUT cycles; a bus answer in that
                // last cycle still takes priority.
                if (wb_ack_i) begin
                    rsp_dat_d    = we_q ? 16'd0 : wb_dat_i;
                    rsp_status_d = ST_OK;
                    state_d      = RESP;
                end else if (wb_err_i) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = GAP;
                    end else begin
                        rsp_dat_d    = 16'd0;
                        rsp_status_d = ST_BERR;
                        state_d      = RESP;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    rsp_dat_d    = 16'd0;
                    rsp_status_d = ST_TOUT;
                    state_d      = RESP;
                end
            end

            GAP: begin
                wdog_d  = 20'd0;
                state_d = BUS;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            adr_q        <= 16'd0;
            dat_q        <= 16'd0;
            wdog_q       <= 20'd0;
            retry_q      <= 3'd0;
            rsp_dat_q    <= 16'd0;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            wdog_q       <= wdog_d;
            retry_q      <= retry_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // All outputs are decoded from registered state, so none of them has a
    // combinational path from an input.
    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign wb_cyc_o   = (state_q == BUS);
    assign wb_stb_o   = (state_q == BUS);
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;

endmodule
